// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel divide/phase/high-time
// pulse trains from one reference clock, with a resync handshake and lock flag.
module clk_enable_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEF_DIV     = 2,
  parameter int unsigned DEF_HIGH    = 1,
  parameter int unsigned LOCK_CYCLES = 16,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_lvl,
  output logic              locked
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_SETTLE,
    S_LOCKED
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH-1:0][CNT_W-1:0] div_q;
  logic [NUM_CH-1:0][CNT_W-1:0] phase_q;
  logic [NUM_CH-1:0][CNT_W-1:0] high_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_CH-1:0][CNT_W-1:0] d_eff;
  logic [NUM_CH-1:0][CNT_W-1:0] load;
  logic [LOCK_W-1:0]            settle_q;
  logic                         active;
  logic                         accept;
  logic                         ch_ok;
  logic                         settle_done;

  assign ch_ok       = 32'(cfg_ch) < NUM_CH;
  assign accept      = cfg_valid & cfg_ready;
  assign settle_done = (settle_q == LOCK_W'(LOCK_CYCLES - 1));

  // Effective divide and SYNC load value; out-of-range phase collapses to 0.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      d_eff[i] = (div_q[i] == '0) ? CNT_W'(1) : div_q[i];
      load[i]  = '0;
      if ((phase_q[i] != '0) && (phase_q[i] < d_eff[i])) begin
        load[i] = d_eff[i] - phase_q[i];
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/lock flags; run low overrides every transition.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    active    = 1'b0;
    locked    = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        state_nxt = S_SYNC;
      end
      S_SYNC: begin
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        active = 1'b1;
        if (settle_done) begin
          state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        active    = 1'b1;
        locked    = 1'b1;
        cfg_ready = 1'b1;
        if (cfg_valid && ch_ok) begin
          state_nxt = S_SYNC;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (!run) begin
      state_nxt = S_IDLE;
    end
  end

  // Shadow registers, phase counters and settle counter.
  always_ff @(posedge refclk) begin
    if (rst) begin
      settle_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        div_q[i]   <= CNT_W'(DEF_DIV);
        phase_q[i] <= '0;
        high_q[i]  <= CNT_W'(DEF_HIGH);
        cnt_q[i]   <= '0;
      end
    end else begin
      settle_q <= (state == S_SETTLE) ? settle_q + LOCK_W'(1) : '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (accept && ch_ok && (cfg_ch == CH_W'(i))) begin
          div_q[i]   <= cfg_div;
          phase_q[i] <= cfg_phase;
          high_q[i]  <= cfg_high;
        end
        if (state_nxt == S_IDLE) begin
          cnt_q[i] <= '0;
        end else if (state == S_SYNC) begin
          cnt_q[i] <= load[i];
        end else if (active) begin
          cnt_q[i] <= (cnt_q[i] >= d_eff[i] - CNT_W'(1)) ? '0 : cnt_q[i] + CNT_W'(1);
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    clk_en  = '0;
    clk_lvl = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (active) begin
        clk_en[i]  = (cnt_q[i] == '0);
        clk_lvl[i] = (cnt_q[i] < high_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: a cycle model queues expected outputs per edge,
// compared at the following falling edge, plus fixed-cycle spot checks.
module tb_clk_enable_gen;

  localparam int unsigned NC   = 3;
  localparam int unsigned CW   = 16;
  localparam int unsigned LOCK = 16;
  localparam int unsigned CHW  = 2;

  localparam int M_IDLE   = 0;
  localparam int M_SYNC   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_LOCKED = 3;

  logic          refclk = 1'b0;
  logic          rst, run, cfg_valid, cfg_ready, locked;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0] cfg_div, cfg_phase, cfg_high;
  logic [NC-1:0] clk_en, clk_lvl;

  always #5 refclk = ~refclk;

  clk_enable_gen #(
    .NUM_CH(NC), .CNT_W(CW), .DEF_DIV(2), .DEF_HIGH(1), .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk(refclk), .rst(rst), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_high(cfg_high),
    .clk_en(clk_en), .clk_lvl(clk_lvl), .locked(locked)
  );

  typedef struct packed {
    logic [NC-1:0] en;
    logic [NC-1:0] lvl;
    logic          lk;
    logic          rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_mode, m_settle, m_e;
  int m_div[NC], m_phase[NC], m_high[NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference behaviour at one rising edge, from the inputs sampled there.
  task automatic model_edge();
    bit acc, okch;
    if (rst) begin
      m_mode = M_IDLE;
      m_settle = 0;
      m_e = 0;
      for (int i = 0; i < int'(NC); i++) begin
        m_div[i] = 2; m_phase[i] = 0; m_high[i] = 1;
      end
    end else begin
      acc  = cfg_valid && (m_mode == M_IDLE || m_mode == M_LOCKED);
      okch = int'(cfg_ch) < int'(NC);
      if (acc && okch) begin
        m_div[cfg_ch]   = int'(cfg_div);
        m_phase[cfg_ch] = int'(cfg_phase);
        m_high[cfg_ch]  = int'(cfg_high);
      end
      if (!run) m_mode = M_IDLE;
      else begin
        case (m_mode)
          M_IDLE: m_mode = M_SYNC;
          M_SYNC: begin m_mode = M_SETTLE; m_settle = 1; m_e = 0; end
          M_SETTLE: begin
            if (m_settle == int'(LOCK)) m_mode = M_LOCKED;
            else m_settle++;
            m_e++;
          end
          default: begin
            if (acc && okch) m_mode = M_SYNC;
            else m_e++;
          end
        endcase
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t r;
    bit act;
    int d, p, pos;
    act = (m_mode == M_SETTLE) || (m_mode == M_LOCKED);
    r.en = '0;
    r.lvl = '0;
    for (int i = 0; i < int'(NC); i++) begin
      d = (m_div[i] == 0) ? 1 : m_div[i];
      p = (m_phase[i] < d) ? m_phase[i] : 0;
      pos = (m_e + d - p) % d;
      r.en[i]  = act && (pos == 0);
      r.lvl[i] = act && (pos < m_high[i]);
    end
    r.lk  = (m_mode == M_LOCKED);
    r.rdy = (m_mode == M_IDLE) || (m_mode == M_LOCKED);
    return r;
  endfunction

  task automatic step(input string tag);
    exp_t e;
    @(posedge refclk);
    model_edge();
    exp_q.push_back(model_out());
    @(negedge refclk);
    e = exp_q.pop_front();
    check({tag, "_en"},    32'(clk_en),    32'(e.en));
    check({tag, "_lvl"},   32'(clk_lvl),   32'(e.lvl));
    check({tag, "_lock"},  32'(locked),    32'(e.lk));
    check({tag, "_ready"}, 32'(cfg_ready), 32'(e.rdy));
  endtask

  task automatic cfg_set(input int ch, input int dv, input int ph, input int hi);
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_div   = CW'(dv);
    cfg_phase = CW'(ph);
    cfg_high  = CW'(hi);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_phase = '0; cfg_high = '0;
    repeat (3) step("rst");
    check("rst_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    step("idle");

    // Defaults: divide 2, high 1, lock after 16 settle cycles
    run = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step("dflt");
      if (n == 1) check("dflt_sync_en", 32'(clk_en), 32'd0);
      if (n == 2) check("dflt_first_en", 32'(clk_en[0]), 32'd1);
      if (n == 3) check("dflt_gap_en", 32'(clk_en[0]), 32'd0);
      if (n == 17) check("dflt_lock_early", 32'(locked), 32'd0);
      if (n == 18) check("dflt_lock", 32'(locked), 32'd1);
    end
    run = 1'b0;
    step("stop1");

    // Phase and divide
    cfg_set(0, 5, 0, 2); step("cfg0");
    cfg_set(1, 5, 3, 5); step("cfg1");
    cfg_valid = 1'b0;
    run = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      step("phase");
      if (n == 2 || n == 7) check("phase_ch0_en", 32'(clk_en[0]), 32'd1);
      if (n == 5 || n == 10) check("phase_ch1_en", 32'(clk_en[1]), 32'd1);
      if (n == 4) check("phase_ch0_lvl_low", 32'(clk_lvl[0]), 32'd0);
      if (n >= 2) check("phase_ch1_lvl", 32'(clk_lvl[1]), 32'd1);
    end

    // Live reconfig in LOCKED; a write held through SETTLE must be ignored
    cfg_set(1, 4, 3, 5);
    step("reconf_acc");
    check("reconf_ready", 32'(cfg_ready), 32'd0);
    check("reconf_unlock", 32'(locked), 32'd0);
    cfg_set(0, 3, 1, 1);
    for (int n = 2; n <= 24; n++) begin
      cfg_valid = (n <= 11);
      step("reconf");
      if (n == 17) check("reconf_lock_early", 32'(locked), 32'd0);
      if (n == 18) check("reconf_lock", 32'(locked), 32'd1);
    end

    // Out-of-range channel: accepted, no effect, stays locked
    cfg_set(3, 1, 0, 0);
    step("badch");
    cfg_valid = 1'b0;
    check("badch_locked", 32'(locked), 32'd1);
    repeat (6) step("badch_run");

    // run falls on the same edge as an accepted write
    cfg_set(0, 3, 0, 1);
    run = 1'b0;
    step("fall_acc");
    cfg_valid = 1'b0;
    check("fall_acc_lock", 32'(locked), 32'd0);
    run = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step("fall_run");
      if (n == 5 || n == 8) check("fall_ch0_div3", 32'(clk_en[0]), 32'd1);
    end
    run = 1'b0;
    step("stop2");

    // Edge values: div 0 behaves as 1, phase >= div behaves as 0
    cfg_set(0, 0, 0, 1); step("cfg_d0");
    cfg_set(1, 4, 7, 2); step("cfg_p7");
    cfg_valid = 1'b0;
    run = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step("edge");
      if (n >= 2) check("edge_ch0_const", 32'(clk_en[0]), 32'd1);
      if (n == 2 || n == 6) check("edge_ch1_en", 32'(clk_en[1]), 32'd1);
    end

    // Drop run in SETTLE
    run = 1'b0;
    step("settle_stop");
    check("settle_stop_en", 32'(clk_en), 32'd0);
    check("settle_stop_lvl", 32'(clk_lvl), 32'd0);
    repeat (3) step("idle2");

    // Reset while LOCKED restores defaults
    run = 1'b1;
    repeat (22) step("pre_rst");
    rst = 1'b1;
    step("mid_rst");
    check("mid_rst_lock", 32'(locked), 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    check("mid_rst_en", 32'(clk_en), 32'd0);
    rst = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      step("post_rst");
      if (n == 2 || n == 4) check("post_rst_en", 32'(clk_en), 32'h7);
      if (n == 3) check("post_rst_lvl", 32'(clk_lvl), 32'h0);
      if (n == 18) check("post_rst_lock", 32'(locked), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
